// File: rtl/parallel_in_serial_out_piso_32_bit.sv
`default_nettype none
// ============================================================================
// Module   : parallel_in_serial_out_piso_32_bit
// Purpose  : Parallel-in / serial-out shift register with a ready/valid load
//            handshake, a shifted-bit counter and a one-cycle frame-done
//            pulse. It is the transmit-side partner of a SIPO that samples
//            Serial_Data_Out on the same Shift_Data_Signal_In edges.
// Ports    :
//   Clk_In               - rising-edge clock
//   Reset_In             - asynchronous active-high reset
//   Enable_In            - block enable; low freezes state, Z on serial out
//   Load_Valid_In        - a parallel word is offered
//   Load_Ready_Out       - word can be accepted (idle and enabled)
//   Parallel_Data_In     - word to transmit, sampled on load
//   Shift_Data_Signal_In - shift strobe, one bit per qualifying edge
//   Serial_Data_Out      - current serial bit (Z while disabled)
//   Serial_Valid_Out     - serial output carries a frame bit
//   Busy_Out             - frame in progress
//   Done_Out             - one-cycle pulse after the final bit
//   Bit_Count_Out        - bits of the current frame already shifted
// Revision : 1.0 - initial release
// ============================================================================
module parallel_in_serial_out_piso_32_bit #(
  parameter int DATA_WIDTH = 32,
  parameter int LSB_FIRST  = 0
) (
  input  logic                                Clk_In,
  input  logic                                Reset_In,
  input  logic                                Enable_In,
  input  logic                                Load_Valid_In,
  output logic                                Load_Ready_Out,
  input  logic [DATA_WIDTH-1:0]               Parallel_Data_In,
  input  logic                                Shift_Data_Signal_In,
  output tri logic                            Serial_Data_Out,
  output logic                                Serial_Valid_Out,
  output logic                                Busy_Out,
  output logic                                Done_Out,
  output logic [$clog2(DATA_WIDTH+1)-1:0]     Bit_Count_Out
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] C_FULL = CW'(DATA_WIDTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [CW-1:0]         bit_count_q, bit_count_d;
  logic                  done_q, done_d;

  logic                  head_bit;
  logic [DATA_WIDTH-1:0] shifted_word;

  // Bit order only changes which end is presented and which way it shifts.
  if (LSB_FIRST != 0) begin : g_lsb_first
    assign head_bit     = shift_reg_q[0];
    assign shifted_word = {1'b0, shift_reg_q[DATA_WIDTH-1:1]};
  end else begin : g_msb_first
    assign head_bit     = shift_reg_q[DATA_WIDTH-1];
    assign shifted_word = {shift_reg_q[DATA_WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_d     = state_q;
    shift_reg_d = shift_reg_q;
    bit_count_d = bit_count_q;
    // Done is a pulse: it falls on the next edge even while disabled.
    done_d      = 1'b0;

    if (Enable_In) begin
      case (state_q)
        ST_IDLE: begin
          // Shift strobe is ignored here, so a load+shift collision is a load.
          if (Load_Valid_In) begin
            shift_reg_d = Parallel_Data_In;
            bit_count_d = '0;
            state_d     = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (Shift_Data_Signal_In) begin
            shift_reg_d = shifted_word;
            if (bit_count_q == C_LAST) begin
              bit_count_d = C_FULL;
              state_d     = ST_IDLE;
              done_d      = 1'b1;
            end else begin
              bit_count_d = bit_count_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q     <= ST_IDLE;
      shift_reg_q <= '0;
      bit_count_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      bit_count_q <= bit_count_d;
      done_q      <= done_d;
    end
  end

  assign Busy_Out         = (state_q == ST_SHIFT);
  assign Done_Out         = done_q;
  assign Bit_Count_Out    = bit_count_q;
  assign Load_Ready_Out   = (state_q == ST_IDLE) & Enable_In;
  assign Serial_Valid_Out = (state_q == ST_SHIFT) & Enable_In;

  // Idle drives a clean 0 so the line never shows a stale frame bit.
  assign Serial_Data_Out  = Enable_In ? ((state_q == ST_SHIFT) ? head_bit : 1'b0) : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_parallel_in_serial_out_piso_32_bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_parallel_in_serial_out_piso_32_bit
// Purpose  : Drives an MSB-first and an LSB-first instance with the same
//            directed stimulus, checks them every cycle against a word/index
//            model of a frame, and loops each serial stream into a SIPO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parallel_in_serial_out_piso_32_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        lv;
  logic [31:0] pd;
  logic        sh;

  logic        rdy_m, val_m, busy_m, done_m;
  logic        rdy_l, val_l, busy_l, done_l;
  logic [5:0]  cnt_m, cnt_l;
  wire         ser_m;
  wire         ser_l;

  // Weak pull makes a released (Z) serial line read as 1.
  pullup (ser_m);
  pullup (ser_l);

  always #5 clk = ~clk;

  parallel_in_serial_out_piso_32_bit #(.DATA_WIDTH(32), .LSB_FIRST(0)) dut_msb (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en),
    .Load_Valid_In(lv), .Load_Ready_Out(rdy_m), .Parallel_Data_In(pd),
    .Shift_Data_Signal_In(sh), .Serial_Data_Out(ser_m), .Serial_Valid_Out(val_m),
    .Busy_Out(busy_m), .Done_Out(done_m), .Bit_Count_Out(cnt_m)
  );

  parallel_in_serial_out_piso_32_bit #(.DATA_WIDTH(32), .LSB_FIRST(1)) dut_lsb (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en),
    .Load_Valid_In(lv), .Load_Ready_Out(rdy_l), .Parallel_Data_In(pd),
    .Shift_Data_Signal_In(sh), .Serial_Data_Out(ser_l), .Serial_Valid_Out(val_l),
    .Busy_Out(busy_l), .Done_Out(done_l), .Bit_Count_Out(cnt_l)
  );

  int checks   = 0;
  int failures = 0;
  int done_seen_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Frame model: a word plus the number of bits already sent.
  bit          m_busy = 0;
  bit          m_done = 0;
  int          m_cnt  = 0;
  logic [31:0] m_word = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_cnt = 0; m_word = '0;
    end else begin
      m_done = 0;
      if (en) begin
        if (!m_busy) begin
          if (lv) begin m_word = pd; m_cnt = 0; m_busy = 1; end
        end else if (sh) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == 32) begin m_busy = 0; m_done = 1; end
        end
      end
    end
  end

  // Receiving SIPOs: MSB-first fills from the right, LSB-first from the left.
  logic [31:0] sipo_m = '0;
  logic [31:0] sipo_l = '0;
  always @(posedge clk) begin
    if (!rst && en && sh) begin
      sipo_m = {sipo_m[30:0], ser_m};
      sipo_l = {ser_l, sipo_l[31:1]};
    end
  end

  always @(negedge clk) begin
    logic exp_m, exp_l;
    if (!en) begin
      exp_m = 1'b1; exp_l = 1'b1;
    end else if (m_busy) begin
      exp_m = m_word[31 - m_cnt];
      exp_l = m_word[m_cnt];
    end else begin
      exp_m = 1'b0; exp_l = 1'b0;
    end
    chk("msb_ready", {31'b0, rdy_m}, {31'b0, !m_busy && en});
    chk("msb_valid", {31'b0, val_m}, {31'b0, m_busy && en});
    chk("msb_busy",  {31'b0, busy_m}, {31'b0, m_busy});
    chk("msb_done",  {31'b0, done_m}, {31'b0, m_done});
    chk("msb_count", {26'b0, cnt_m}, m_cnt);
    chk("msb_serial", {31'b0, ser_m}, {31'b0, exp_m});
    chk("lsb_ready", {31'b0, rdy_l}, {31'b0, !m_busy && en});
    chk("lsb_valid", {31'b0, val_l}, {31'b0, m_busy && en});
    chk("lsb_busy",  {31'b0, busy_l}, {31'b0, m_busy});
    chk("lsb_done",  {31'b0, done_l}, {31'b0, m_done});
    chk("lsb_count", {26'b0, cnt_l}, m_cnt);
    chk("lsb_serial", {31'b0, ser_l}, {31'b0, exp_l});
    if (done_m === 1'b1) done_seen_m++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] w);
    lv = 1'b1; pd = w;
    tick();
    lv = 1'b0;
  endtask

  task automatic shift_n(input int n);
    sh = 1'b1;
    repeat (n) tick();
    sh = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1; en = 1'b1; lv = 1'b0; pd = '0; sh = 1'b0;
    tick(); tick();
    chk("reset_count", {26'b0, cnt_m}, 32'd0);
    chk("reset_ready", {31'b0, rdy_m}, 32'd1);
    chk("reset_serial", {31'b0, ser_m}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic MSB-first frame.
    done_seen_m = 0;
    load(32'hA5A5_F00D);
    chk("basic_first_bit", {31'b0, ser_m}, 32'd1);
    shift_n(1);
    chk("basic_second_bit", {31'b0, ser_m}, 32'd0);
    shift_n(31);
    chk("basic_done", {31'b0, done_m}, 32'd1);
    chk("basic_count_full", {26'b0, cnt_m}, 32'd32);
    chk("basic_busy_low", {31'b0, busy_m}, 32'd0);
    tick();
    chk("basic_done_once", done_seen_m, 32'd1);
    chk("basic_sipo_msb", sipo_m, 32'hA5A5_F00D);
    chk("basic_sipo_lsb", sipo_l, 32'hA5A5_F00D);

    // Loopback of random words, back-to-back frames.
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      load(w);
      shift_n(32);
      chk("loop_sipo_msb", sipo_m, w);
      chk("loop_sipo_lsb", sipo_l, w);
    end
    tick();

    // Gapped shifting and enable freeze.
    load(32'hDEAD_BEEF);
    shift_n(10);
    chk("gap_count10", {26'b0, cnt_m}, 32'd10);
    repeat (5) tick();
    chk("gap_count_hold", {26'b0, cnt_m}, 32'd10);
    en = 1'b0; sh = 1'b1; lv = 1'b1; pd = 32'h0;
    repeat (3) begin
      tick();
      chk("dis_valid", {31'b0, val_m}, 32'd0);
      chk("dis_serial_released", {31'b0, ser_m}, 32'd1);
    end
    sh = 1'b0; lv = 1'b0; en = 1'b1;
    tick();
    chk("dis_count_hold", {26'b0, cnt_m}, 32'd10);
    shift_n(22);
    chk("gap_sipo_msb", sipo_m, 32'hDEAD_BEEF);
    tick();

    // Load offered mid-frame is ignored.
    load(32'h1357_9BDF);
    shift_n(5);
    lv = 1'b1; pd = 32'hFFFF_FFFF; sh = 1'b1;
    tick();
    lv = 1'b0;
    shift_n(26);
    chk("busy_load_sipo", sipo_m, 32'h1357_9BDF);
    tick();

    // Load and shift together in idle: load wins.
    lv = 1'b1; pd = 32'h8000_0000; sh = 1'b1;
    tick();
    lv = 1'b0; sh = 1'b0;
    chk("collide_count", {26'b0, cnt_m}, 32'd0);
    chk("collide_first_bit", {31'b0, ser_m}, 32'd1);
    chk("collide_busy", {31'b0, busy_m}, 32'd1);
    shift_n(32);
    chk("collide_sipo", sipo_m, 32'h8000_0000);
    tick();

    // Asynchronous reset mid-frame.
    load(32'h1234_5678);
    shift_n(12);
    #2 rst = 1'b1;
    #1;
    chk("areset_busy", {31'b0, busy_m}, 32'd0);
    chk("areset_count", {26'b0, cnt_m}, 32'd0);
    chk("areset_serial", {31'b0, ser_m}, 32'd0);
    chk("areset_done", {31'b0, done_m}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    load(32'hCAFE_0042);
    shift_n(32);
    chk("after_reset_sipo", sipo_m, 32'hCAFE_0042);
    tick();

    // LSB-first single set bit, and done clearing while disabled.
    load(32'h0000_0001);
    chk("lsb_first_bit", {31'b0, ser_l}, 32'd1);
    shift_n(1);
    chk("lsb_second_bit", {31'b0, ser_l}, 32'd0);
    shift_n(30);
    chk("lsb_bit31", {31'b0, ser_l}, 32'd0);
    chk("lsb_no_early_done", {31'b0, done_l}, 32'd0);
    shift_n(1);
    chk("lsb_done", {31'b0, done_l}, 32'd1);
    chk("lsb_count_full", {26'b0, cnt_l}, 32'd32);
    en = 1'b0;
    tick();
    chk("lsb_done_clears_disabled", {31'b0, done_l}, 32'd0);
    en = 1'b1;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
